// File: rtl/core_defines.sv
// Shared core-wide definitions.
//   CORE_PC_WIDTH   : width of a program counter value
//   CORE_INST_WIDTH : width of one fetched instruction
package core_defines;

    localparam int CORE_PC_WIDTH   = 32;
    localparam int CORE_INST_WIDTH = 32;

endpackage

// File: rtl/core_if_ibuf_ptr.sv
// Pointer and occupancy tracking for the instruction buffer.
// Ports:
//   clk, rst           : core clock, synchronous active-high reset
//   flush              : clears pointers and count (same effect as reset)
//   push, pop          : one-entry write / read this cycle
//   wr_ptr, rd_ptr     : circular write / read indices (wrap by overflow)
//   count              : occupancy 0..DEPTH
module core_if_ibuf_ptr #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W:0] count_d;

    always_comb begin
        count_d = count;
        unique case ({push, pop})
            2'b10:   count_d = count + (PTR_W + 1)'(1);
            2'b01:   count_d = count - (PTR_W + 1)'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_d;
        end
    end

    // Upstream gating by ready_in must make this unreachable.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && count == FULL))
        else $error("core_if_ibuf_ptr: push while full");

endmodule

// File: rtl/core_if_ibuf.sv
// Instruction buffer between fetch (IFU) and decode.
// Stores {pc, inst, bj_predict} beats in a DEPTH-entry circular FIFO,
// presents them in order, and drops everything on an EXU pipeline flush.
// Ports:
//   clk, rst                       : core clock, synchronous active-high reset
//   valid_in / ready_in            : IFU handshake (ready_in independent of ready_out)
//   i_pc, i_inst, i_bj_predict     : incoming beat
//   i_pipe_flush_req               : flush; wins over push and pop
//   valid_out / ready_out          : decode handshake
//   o_pc, o_inst, o_bj_predict     : head entry (don't-care when valid_out = 0)
//   o_count                        : occupancy 0..DEPTH
// Config macro: CORE_IBUF_BYPASS_EN - when empty, the input beat passes straight
// to the outputs and is consumed without being written if decode is ready.
module core_if_ibuf
    import core_defines::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  logic [CORE_PC_WIDTH-1:0]   i_pc,
    input  logic [CORE_INST_WIDTH-1:0] i_inst,
    input  logic                       i_bj_predict,
    input  logic                       i_pipe_flush_req,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [CORE_PC_WIDTH-1:0]   o_pc,
    output logic [CORE_INST_WIDTH-1:0] o_inst,
    output logic                       o_bj_predict,
    output logic [PTR_W:0]             o_count
);

    localparam int ENTRY_W = CORE_PC_WIDTH + CORE_INST_WIDTH + 1;
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               empty;
    logic               push;
    logic               wr_en;
    logic               ptr_pop;

    assign empty    = (count == '0);
    assign ready_in = (count != FULL);
    assign push     = valid_in & ready_in & ~i_pipe_flush_req;
    assign head     = mem[rd_ptr];

    always_comb begin
        valid_out    = ~empty & ~i_pipe_flush_req;
        o_pc         = head[ENTRY_W-1 -: CORE_PC_WIDTH];
        o_inst       = head[CORE_INST_WIDTH:1];
        o_bj_predict = head[0];
        wr_en        = push;
        ptr_pop      = valid_out & ready_out;
`ifdef CORE_IBUF_BYPASS_EN
        if (empty) begin
            valid_out    = valid_in & ~i_pipe_flush_req;
            o_pc         = i_pc;
            o_inst       = i_inst;
            o_bj_predict = i_bj_predict;
            // Beat taken directly by decode: never enters storage.
            wr_en        = push & ~ready_out;
            ptr_pop      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {i_pc, i_inst, i_bj_predict};
    end

    core_if_ibuf_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ptr (
        .clk    (clk),
        .rst    (rst),
        .flush  (i_pipe_flush_req),
        .push   (wr_en),
        .pop    (ptr_pop),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count)
    );

    assign o_count = count;

endmodule
